// File: rtl/router_pkg.sv
// Shared types for the router egress stage: data width, packet length, beat tag and buffer entry.
// No logic; types only.
// Optional parity field controlled by ROUTER_EGRESS_PARITY_EN.
package router_pkg;

  localparam int WIDTH   = 64;
  localparam int PKT_LEN = 4;

  typedef logic [$clog2(PKT_LEN)-1:0] beat_t;

  // One buffered word with its framing, tagged when it is written.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sop;
    logic             eop;
`ifdef ROUTER_EGRESS_PARITY_EN
    logic             parity;
`endif
  } egress_entry_t;

endpackage

// File: rtl/egress_skid_buf.sv
// Purpose: 2-entry in-order buffer of egress entries; entry 0 is always the head.
// Latency: a write at the end of cycle t is visible at the head in cycle t+1 if the buffer was empty.
// Backpressure: holds the head stable while rd_valid && !rd_ready; the writer must respect occ.
module egress_skid_buf
  import router_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  egress_entry_t wr_data,
  output egress_entry_t rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [1:0]    occ
);

  egress_entry_t entry0;
  egress_entry_t entry1;
  logic          rd_en;

  assign rd_en    = rd_valid && rd_ready;
  assign rd_valid = (occ != 2'd0);
  assign rd_data  = entry0;

  // Occupancy and entry storage; a read shifts entry1 into the head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ    <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          if (occ == 2'd0) begin
            entry0 <= wr_data;
            occ    <= 2'd1;
          end else if (occ == 2'd1) begin
            entry1 <= wr_data;
            occ    <= 2'd2;
          end
          // A write into a full buffer is excluded by the pop rule upstream.
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            entry0 <= wr_data;
          end else begin
            entry0 <= entry1;
            entry1 <= wr_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/router_egress.sv
// Purpose: drains dst_fifo into a framed valid/ready packet stream and counts completed packets.
// Latency: pop in cycle t, data written end of t+1, out_valid in t+2; 1 word/clk sustained.
// Backpressure: pops only while buffered + in-flight words stay below 2; ROUTER_EGRESS_PARITY_EN adds out_parity.
module router_egress #(
  parameter int WIDTH   = 64,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [CNT_W-1:0] pkt_count
`ifdef ROUTER_EGRESS_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  import router_pkg::*;

  localparam beat_t LAST_BEAT = beat_t'(PKT_LEN - 1);

  logic          inflight;
  beat_t         beat;
  logic          xfer;
  logic [1:0]    occ;
  logic [1:0]    level;
  egress_entry_t wr_entry;
  egress_entry_t head;

  assign xfer = out_valid && out_ready;

  // Words committed after this cycle; xfer only happens with occ>=1 so this never underflows.
  assign level    = occ + {1'b0, inflight} - {1'b0, xfer};
  assign fifo_pop = reset && !fifo_empty && (level < 2'd2);

  // Tag the returning word with its position in the packet.
  always_comb begin
    wr_entry        = '0;
    wr_entry.data   = fifo_data;
    wr_entry.sop    = (beat == '0);
    wr_entry.eop    = (beat == LAST_BEAT);
`ifdef ROUTER_EGRESS_PARITY_EN
    wr_entry.parity = ^fifo_data;
`endif
  end

  egress_skid_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (inflight),
    .wr_data  (wr_entry),
    .rd_data  (head),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .occ      (occ)
  );

  assign out_data = head.data;
  assign out_sop  = head.sop;
  assign out_eop  = head.eop;
`ifdef ROUTER_EGRESS_PARITY_EN
  assign out_parity = head.parity;
`endif

  // Track the pop in flight; clearing it on reset discards data from a pre-reset pop.
  always_ff @(posedge clk) begin
    if (!reset) inflight <= 1'b0;
    else        inflight <= fifo_pop;
  end

  // Advance the beat per written word; it holds across fifo underflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat <= '0;
    end else if (inflight) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + beat_t'(1);
    end
  end

  // Count packets leaving on their eop beat, saturating at all ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (xfer && out_eop && (pkt_count != {CNT_W{1'b1}})) begin
      pkt_count <= pkt_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_router_egress.sv
// Randomized and directed bench for router_egress against a queue-based reference model.
// Runs the DUT with CNT_W=2 so packet-count saturation is reachable.
// Checks parity too when ROUTER_EGRESS_PARITY_EN is defined.
module tb_router_egress;

  localparam int W    = 64;
  localparam int PL   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [W-1:0]  fifo_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sop;
  logic          out_eop;
  logic [CW-1:0] pkt_count;
`ifdef ROUTER_EGRESS_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  router_egress #(.WIDTH(W), .PKT_LEN(PL), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .pkt_count  (pkt_count)
`ifdef ROUTER_EGRESS_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  // Reference model: words the FIFO still holds, words written but not yet sent,
  // the word returning from a pop, written-word count (for framing) and packet count.
  typedef struct {
    logic [W-1:0] d;
    int           pos;
  } mword_t;

  logic [W-1:0] src[$];
  mword_t       mq[$];
  bit           pend;
  logic [W-1:0] pend_d;
  int           wcount;
  int           mcnt;
  bit           was_reset;
  int           n_xfer;
  int           n_chk;
  int           n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    pend   = 1'b0;
    wcount = 0;
    mcnt   = 0;
  endtask

  // One clock: drive inputs at negedge, check DUT against model, advance model, return FIFO data.
  task automatic cycle(input bit rst_i, input bit rdy_i);
    bit     ev;
    bit     ex;
    bit     ep;
    bit     popped;
    mword_t h;
    @(negedge clk);
    reset      = rst_i;
    out_ready  = rdy_i;
    fifo_empty = (src.size() == 0);
    #1;
    ev = (mq.size() > 0);
    ex = ev && rdy_i;
    ep = rst_i && !fifo_empty && ((mq.size() + int'(pend) - int'(ex)) < 2);
    chk("fifo_pop", fifo_pop, ep);
    chk("out_valid", out_valid, ev);
    chk("pkt_count", pkt_count, mcnt);
    if (was_reset) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sop", out_sop, 0);
      chk("rst_out_eop", out_eop, 0);
    end
    if (ev) begin
      h = mq[0];
      chk("out_data", out_data, h.d);
      chk("out_sop", out_sop, h.pos == 0);
      chk("out_eop", out_eop, h.pos == PL - 1);
`ifdef ROUTER_EGRESS_PARITY_EN
      chk("out_parity", out_parity, ^h.d);
`endif
    end
    popped = fifo_pop;
    if (!rst_i) begin
      model_reset();
      was_reset = 1'b1;
    end else begin
      was_reset = 1'b0;
      if (ex) begin
        h = mq.pop_front();
        n_xfer++;
        if (h.pos == PL - 1 && mcnt < CMAX) mcnt++;
      end
      if (pend) begin
        mq.push_back('{d: pend_d, pos: wcount % PL});
        wcount++;
      end
      pend = popped;
      if (popped && src.size() > 0) pend_d = src[0];
    end
    @(posedge clk);
    #1;
    if (popped && src.size() > 0) fifo_data = src.pop_front();
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) src.push_back(W'(first + i));
  endtask

  initial begin
    bit done;
    n_chk = 0; n_pass = 0; n_xfer = 0;
    reset = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    was_reset = 1'b1;

    // Reset held with a non-empty FIFO: nothing pops or emits.
    push_words(1, 8);
    repeat (5) cycle(1'b0, 1'b1);

    // Streaming 0x1..0x8 with the link always ready: two packets.
    n_xfer = 0;
    repeat (12) cycle(1'b1, 1'b1);
    chk("stream_words", n_xfer, 8);
    chk("stream_pkts", pkt_count, 2);

    // Backpressure for 5 cycles mid-stream, then release.
    push_words(9, 8);
    repeat (3) cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b1, 1'b1);
    chk("bp_words", n_xfer, 16);

    // Underflow after two words of a packet, then resume with the remaining two.
    push_words(17, 2);
    repeat (6) cycle(1'b1, 1'b1);
    push_words(19, 2);
    repeat (6) cycle(1'b1, 1'b1);
    chk("uf_words", n_xfer, 20);

    // Reset while the buffer is full, and reset right after a pop.
    push_words(32, 8);
    repeat (2) cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b1);
    push_words(48, 4);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1);

    // Saturation: five packets after reset leave the counter at its maximum.
    repeat (2) cycle(1'b0, 1'b1);
    push_words(64, 5 * PL);
    repeat (5 * PL + 6) cycle(1'b1, 1'b1);
    chk("sat_count", pkt_count, CMAX);

    // Randomized traffic, link stalls and occasional resets.
    repeat (2) cycle(1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0 && src.size() < 16)
        push_words(int'($urandom_range(0, 32'h7fff_ffff)), int'($urandom_range(1, 6)));
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);
    end

    // Drain everything with a bounded budget.
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle(1'b1, 1'b1);
      done = (src.size() == 0) && (mq.size() == 0) && !pend;
    end
    chk("drain", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
